bus_master_ctrl: RTL
====================

# bus_master_ctrl

Bus master sequencer placed between one MIPS32 memory client (instruction fetch or load/store unit) and the shared system bus. It converts a single-word read/write request into the bus protocol: it requests the bus from `busarb`, waits for the grant, drives address/data strobes, and waits for memory ready with a timeout. It then signals `done` to release the arbiter and returns data or an error to the client. One instance exists per arbiter port (port 0 and port 1).

## Interface
- `ADDR_W`, 30: word-address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum WAIT cycles before abort; must be ≥1.

Ports:
- `clk` in 1: single clock.
- `reset_` in 1: asynchronous, active-low reset.
- `req` in 1: client request, active high; sampled only in IDLE.
- `we` in 1: 1 = write, 0 = read; latched with `req`.
- `addr` in ADDR_W: word address; latched with `req`.
- `wdata` in DATA_W: write data; latched with `req`.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: valid with `ack`; 1 = timeout or grant lost.
- `rdata` out DATA_W: read data; valid with `ack`, held until the next read completes.
- `breq_` out 1: bus request to arbiter, active low.
- `bgrt_` in 1: bus grant from arbiter, active low.
- `done` out 1: release pulse to arbiter, active high.
- `as_` out 1: address strobe, active low.
- `rw_` out 1: 0 = write cycle, 1 = read cycle; valid while `as_`=0.
- `bus_addr` out ADDR_W: bus address.
- `bus_wdata` out DATA_W: bus write data.
- `bus_oe` out 1: write-data drive enable.
- `rdy_` in 1: memory ready, active low.
- `bus_rdata` in DATA_W: memory read data.

## Operation
- All outputs are registered. Reset values: `breq_`=1, `as_`=1, `rw_`=1, `bus_oe`=0, `done`=0, `ack`=0, `err`=0, `rdata`=0, `bus_addr`=0, `bus_wdata`=0, state=IDLE, timeout counter=0.
- States and transitions:
  - **IDLE**: on `req`=1, latch `we`/`addr`/`wdata` and go to REQ. The client may drop `req` after this edge.
  - **REQ**: `breq_`=0. On sampled `bgrt_`=0, go to ADDR.
  - **ADDR**: `as_`=0, `rw_`=~`we`, `bus_addr`=latched address. On writes, `bus_oe`=1 and `bus_wdata`=latched data. Always go to WAIT.
  - **WAIT**: strobes held. The counter increments each cycle.
    - `rdy_`=0 → capture `bus_rdata` (reads only) and go to REL with err=0.
    - Counter reaches TIMEOUT with `rdy_`=1 → go to REL with err=1.
  - **REL**: `as_`=1, `bus_oe`=0, `breq_`=1, `done`=1, `ack`=1, `err` per cause. Counter cleared. Go to IDLE.
- Grant lost: `bgrt_`=1 sampled in ADDR or WAIT is a protocol fault. Drop strobes immediately, go to IDLE, and pulse `ack`=1, `err`=1. `done` is not asserted because the arbiter is already free.
- `req` outside IDLE is ignored. A `req` in the REL cycle is accepted in the following IDLE cycle.
- `rdy_` is ignored outside WAIT.
- `rdata` is unchanged on writes and on errors.

## Timing
- Minimum latency: `req` sampled at edge 0 → `breq_` low in cycle 1 → `bgrt_` low in cycle 2 → ADDR in cycle 3 → WAIT in cycle 4 (`rdy_`=0) → REL/`ack` in cycle 5.
- Each memory wait state adds 1 cycle.
- Arbitration against the other port adds its full hold time.
- `breq_` is high for at least the REL cycle plus the IDLE cycle between transactions. This guarantees the arbiter sees `done` with `breq_` deasserted, so it never re-grants a finished master.
- `done` and `ack` are always exactly one cycle wide.
- Timeout `ack` occurs TIMEOUT+1 cycles after entering WAIT.
- Asynchronous reset in any state forces the reset values within the same cycle; no `done` is issued, because the arbiter shares the reset net.

## Structure
- The shared `define.h` holds:
  - state encodings (`MS_IDLE`, `MS_REQ`, `MS_ADDR`, `MS_WAIT`, `MS_REL`);
  - `Read`/`Write` levels;
  - reuse of the existing `Enable_`/`Disable_`/`Enable` macros.
- One sub-module, `bus_wdt`: a loadable timeout counter with clear, enable and `expired` outputs, width $clog2(TIMEOUT+1).

## Test plan
- Read with zero waits: `req`, `we`=0, `addr`=0x100, `bgrt_` low in cycle 2, `rdy_`=0 in cycle 4, `bus_rdata`=0xDEADBEEF → `ack` in cycle 5, `rdata`=0xDEADBEEF, `err`=0, `done`=1 in cycle 5.
- Write with 3 wait states: `wdata`=0x12345678 → `bus_oe`=1 and `rw_`=0 from cycle 3 to cycle 7; `ack` in cycle 8; `rdata` unchanged.
- Timeout with TIMEOUT=4 and `rdy_` held high → `ack`=`err`=1 exactly 5 cycles after WAIT entry, `done`=1, strobes released.
- Two instances plus `busarb` with simultaneous `req` → grants alternate 0,1,0,1 and there is never any overlap of `as_`.
- Grant withdrawn in WAIT → next cycle `as_`=1, `ack`=`err`=1, `done`=0, state IDLE.
- `reset_` asserted in WAIT → all outputs reach reset values asynchronously; after release a new `req` completes normally.

Source files
------------

// File: rtl/bus_master_ctrl_pkg.sv
// Shared definitions for the bus master sequencer: state encoding, bus levels
// and the watchdog width helper.
package bus_master_ctrl_pkg;

  typedef enum logic [2:0] {
    MS_IDLE = 3'd0,
    MS_REQ  = 3'd1,
    MS_ADDR = 3'd2,
    MS_WAIT = 3'd3,
    MS_REL  = 3'd4
  } ms_state_e;

  // rw_ levels on the system bus
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Active-low strobe levels (breq_, as_, bgrt_, rdy_)
  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

  function automatic int wdt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_master_ctrl_if.sv
// System-bus side of one arbiter port: arbitration handshake, strobes and data.
interface bus_master_ctrl_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              breq_;
  logic              bgrt_;
  logic              done;
  logic              as_;
  logic              rw_;
  logic              bus_oe;
  logic              rdy_;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output breq_, done, as_, rw_, bus_addr, bus_wdata, bus_oe,
    input  bgrt_, rdy_, bus_rdata
  );

  modport slave (
    input  breq_, done, as_, rw_, bus_addr, bus_wdata, bus_oe,
    output bgrt_, rdy_, bus_rdata
  );
endinterface

// File: rtl/bus_master_ctrl_wdt.sv
// Memory-ready watchdog: saturating up-counter with clear, load and enable;
// expired is high once the count equals TIMEOUT.
module bus_master_ctrl_wdt
  import bus_master_ctrl_pkg::*;
#(
  parameter  int TIMEOUT = 255,
  localparam int CNT_W   = wdt_width(TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)               count <= '0;
    else if (clr)              count <= '0;
    else if (load)             count <= load_val;
    else if (en && !expired)   count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/bus_master_ctrl.sv
// Single-word bus master: requests the bus, runs one strobed read/write cycle
// with a ready timeout, then releases the arbiter and acknowledges the client.
module bus_master_ctrl
  import bus_master_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  bus_master_ctrl_if.master bus
);

  ms_state_e         state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fault, timeout_hit, capture, strobe_d, wdt_expired;

  bus_master_ctrl_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk      (clk),
    .reset_   (reset_),
    .clr      ((state_q == MS_REL) || fault),
    .load     (1'b0),
    .load_val ('0),
    .en       (state_q == MS_WAIT),
    .expired  (wdt_expired)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_q <= MS_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred; comb logic uses '=' only.
  always_comb begin
    state_d     = state_q;
    fault       = 1'b0;
    timeout_hit = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      MS_IDLE: if (req) state_d = MS_REQ;
      MS_REQ:  if (bus.bgrt_ == ENABLE_N) state_d = MS_ADDR;
      MS_ADDR: begin
        if (bus.bgrt_ == DISABLE_N) begin
          fault   = 1'b1;
          state_d = MS_IDLE;
        end else begin
          state_d = MS_WAIT;
        end
      end
      MS_WAIT: begin
        // A lost grant outranks a simultaneous ready: the cycle is not ours.
        if (bus.bgrt_ == DISABLE_N) begin
          fault   = 1'b1;
          state_d = MS_IDLE;
        end else if (bus.rdy_ == ENABLE_N) begin
          capture = !we_q;
          state_d = MS_REL;
        end else if (wdt_expired) begin
          timeout_hit = 1'b1;
          state_d     = MS_REL;
        end
      end
      MS_REL:  state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  assign strobe_d = (state_d == MS_ADDR) || (state_d == MS_WAIT);

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order. The request latches are
  // reset too, keeping the whole block deterministic out of reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == MS_IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Outputs are registered from the next state, so they line up with it.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bus.breq_     <= DISABLE_N;
      bus.as_       <= DISABLE_N;
      bus.rw_       <= RW_READ;
      bus.bus_oe    <= 1'b0;
      bus.done      <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      ack           <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
    end else begin
      bus.breq_  <= (state_d inside {MS_REQ, MS_ADDR, MS_WAIT}) ? ENABLE_N : DISABLE_N;
      bus.as_    <= strobe_d ? ENABLE_N : DISABLE_N;
      bus.rw_    <= (strobe_d && we_q) ? RW_WRITE : RW_READ;
      bus.bus_oe <= strobe_d && we_q;
      bus.done   <= (state_d == MS_REL);
      ack        <= (state_d == MS_REL) || fault;
      err        <= timeout_hit || fault;
      if (state_q == MS_REQ && state_d == MS_ADDR) begin
        bus.bus_addr <= addr_q;
        if (we_q) bus.bus_wdata <= wdata_q;
      end
      if (capture) rdata <= bus.bus_rdata;
    end
  end

endmodule
